sprite_palette_lut: RTL and testbench
=====================================

Name: sprite_palette_lut

Overview:
- Parametrised, runtime-writable colour palette for sprite pixels in the VGA render path.
- Sits between the sprite ROM index stream and the pixel mux. Maps palette select plus colour index to 12-bit RGB through a 2-cycle pipeline.
- Adds per-frame damage-flash override, a transparency flag and a CPU/game-logic write port.

Parameters:
- NUM_PALETTES, 4: palettes held (e.g. one per crewmate colour).
- INDEX_W, 3: colour index width; each palette holds 2^INDEX_W entries.
- COLOR_W, 12: output colour width, packed {R[3:0],G[3:0],B[3:0]}.
- FLASH_FRAMES, 8: frames the flash override lasts. Range 1..255.
- PSEL_W, max(1,$clog2(NUM_PALETTES)): derived palette-select width.

Ports:
- Clk  in  1  pixel clock
- Reset  in  1  synchronous, active-high
- pix_valid_in  in  1  index/select valid this cycle
- palette_sel  in  PSEL_W  palette to use
- color_index  in  INDEX_W  colour index from sprite ROM
- wr_en  in  1  palette entry write strobe
- wr_palette  in  PSEL_W  palette being written
- wr_index  in  INDEX_W  entry being written
- wr_color  in  COLOR_W  new entry value
- flash_start  in  1  start or restart the flash
- frame_tick  in  1  one-cycle pulse per frame (vsync edge)
- pix_valid_out  out  1  output pixel valid
- color_out  out  COLOR_W  resolved colour
- transparent_out  out  1  pixel is transparent (index 0)
- flash_active  out  1  flash counter nonzero

Behaviour:

Reset (synchronous, active-high; applies mid-operation as well):
- Clears all pipeline valids, color_out, transparent_out and flash_active to 0, and clears the flash counter.
- Reloads palette storage:
  - Palette 0, idx0..7: 000, B00, CB1, FD0, 040, 3FD, 456, 9CD.
  - All other entries: 000.

Storage:
- Register array of NUM_PALETTES*2^INDEX_W entries, each COLOR_W wide.
- Writes with wr_en=1 commit at the clock edge.
- A write with wr_palette >= NUM_PALETTES is ignored.

Pipeline (latency 2 cycles, fully pipelined, one pixel per cycle, no stalls):
- S1 registers pix_valid_in, palette_sel and color_index.
- S2 reads storage using the S1 registers and registers the outputs.
- palette_sel >= NUM_PALETTES resolves to palette 0.

Read/write collision:
- If S2 reads an entry in the same cycle that entry is written, S2 returns the old value.
- Pixels entering S2 on the next cycle see the new value.

Output rules (evaluated in S2):
- valid=0: pix_valid_out=0, color_out=000, transparent_out=0.
- index==0: transparent_out=1, color_out=000. Flash does not apply.
- Otherwise, flash counter nonzero: color_out = all ones (FFF).
- Otherwise: color_out = the stored entry.

Flash counter (width $clog2(FLASH_FRAMES+1)):
- flash_start loads FLASH_FRAMES. This restarts the flash if already active.
- frame_tick decrements the counter when nonzero and holds it at 0 otherwise.
- flash_start and frame_tick in the same cycle: the load wins.
- flash_active is registered and equals (counter != 0).
- S2 uses the counter value present in the cycle it resolves the pixel.

Test Plan:
- Reset, then stream palette 0 idx1..7 on consecutive cycles -> two cycles later color_out = B00, CB1, FD0, 040, 3FD, 456, 9CD back-to-back, with pix_valid_out high for 7 cycles.
- Write palette 2 idx5 = 0F0, then read pal2 idx5 -> 0F0. Also write and read the same entry in the same cycle (with the read reaching S2 that cycle) -> old value 000 out; next read -> 0F0.
- idx0 on any palette with flash active -> transparent_out=1, color_out=000. pix_valid_in=0 -> pix_valid_out=0, color_out=000.
- flash_start, then 8 frame_ticks -> idx2 reads FFF until the 8th tick, then CB1. flash_start coincident with a tick at count 3 -> count reloads to 8.
- palette_sel=5 with NUM_PALETTES=5 -> palette 0 colour. Write to palette 5 -> no entry changes.
- Reset asserted mid-stream after writing pal0 idx1 = 123 -> outputs 0 the next cycle, pal0 idx1 reads B00 again, flash_active=0.

Source files
------------

// File: rtl/sprite_palette_lut.sv
// sprite_palette_lut: runtime-writable sprite colour palette for the VGA render path.
// Maps {palette_sel, color_index} to a packed 12-bit RGB value through a
// two-stage pipeline. It adds a per-frame damage-flash override, a
// transparency flag for index 0, and a CPU/game-logic write port.
module sprite_palette_lut #(
    parameter int unsigned NUM_PALETTES = 4,
    parameter int unsigned INDEX_W      = 3,
    parameter int unsigned COLOR_W      = 12,
    parameter int unsigned FLASH_FRAMES = 8,
    parameter int unsigned PSEL_W       = (NUM_PALETTES > 1) ? $clog2(NUM_PALETTES) : 1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               pix_valid_in,
    input  logic [PSEL_W-1:0]  palette_sel,
    input  logic [INDEX_W-1:0] color_index,
    input  logic               wr_en,
    input  logic [PSEL_W-1:0]  wr_palette,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [COLOR_W-1:0] wr_color,
    input  logic               flash_start,
    input  logic               frame_tick,
    output logic               pix_valid_out,
    output logic [COLOR_W-1:0] color_out,
    output logic               transparent_out,
    output logic               flash_active
);

    localparam int unsigned NUM_COLORS  = 1 << INDEX_W;
    localparam int unsigned NUM_ENTRIES = NUM_PALETTES * NUM_COLORS;
    localparam int unsigned ADDR_W      = PSEL_W + INDEX_W;
    localparam int unsigned CNT_W       = $clog2(FLASH_FRAMES + 1);

    // Power-up contents: palette 0 carries the default crewmate ramp, all else black.
    function automatic logic [COLOR_W-1:0] reset_color(input int unsigned entry);
        logic [11:0] rgb;
        rgb = 12'h000;
        if (entry < NUM_COLORS) begin
            case (entry)
                1:       rgb = 12'hB00;
                2:       rgb = 12'hCB1;
                3:       rgb = 12'hFD0;
                4:       rgb = 12'h040;
                5:       rgb = 12'h3FD;
                6:       rgb = 12'h456;
                7:       rgb = 12'h9CD;
                default: rgb = 12'h000;
            endcase
        end
        return COLOR_W'(rgb);
    endfunction

    // Palette storage
    logic [COLOR_W-1:0] pal_mem_q [NUM_ENTRIES];
    logic               wr_ok_c;
    logic [ADDR_W-1:0]  wr_addr_c;

    // S1 pipeline registers
    logic               s1_valid_q, s1_valid_d;
    logic [PSEL_W-1:0]  s1_psel_q,  s1_psel_d;
    logic [INDEX_W-1:0] s1_idx_q,   s1_idx_d;

    // S2 read path
    logic [PSEL_W-1:0]  rd_pal_c;
    logic [ADDR_W-1:0]  rd_addr_c;
    logic [COLOR_W-1:0] rd_color_c;

    // S2 output registers
    logic               out_valid_q,  out_valid_d;
    logic [COLOR_W-1:0] out_color_q,  out_color_d;
    logic               out_transp_q, out_transp_d;

    // Flash override state
    logic [CNT_W-1:0]   flash_cnt_q, flash_cnt_d;
    logic               flash_act_q, flash_act_d;

    // Write-port decode; a write to a palette that does not exist is dropped.
    always_comb begin
        wr_ok_c   = wr_en && (32'(wr_palette) < NUM_PALETTES);
        wr_addr_c = {wr_palette, wr_index};
    end

    // Storage update: reset reloads the defaults, otherwise commit writes at the edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int unsigned e = 0; e < NUM_ENTRIES; e++) begin
                pal_mem_q[ADDR_W'(e)] <= reset_color(e);
            end
        end else if (wr_ok_c) begin
            pal_mem_q[wr_addr_c] <= wr_color;
        end
    end

    // S1 capture of the incoming pixel request.
    always_comb begin
        s1_valid_d = pix_valid_in;
        s1_psel_d  = palette_sel;
        s1_idx_d   = color_index;
    end

    // S1 registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid_q <= 1'b0;
            s1_psel_q  <= '0;
            s1_idx_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_psel_q  <= s1_psel_d;
            s1_idx_q   <= s1_idx_d;
        end
    end

    // S2 read: out-of-range selects fall back to palette 0. Reading the
    // registered array gives old data when the same entry is written this cycle.
    always_comb begin
        rd_pal_c   = (32'(s1_psel_q) < NUM_PALETTES) ? s1_psel_q : '0;
        rd_addr_c  = {rd_pal_c, s1_idx_q};
        rd_color_c = pal_mem_q[rd_addr_c];
    end

    // S2 resolve: transparency beats flash, flash beats the stored colour.
    always_comb begin
        out_valid_d  = s1_valid_q;
        out_transp_d = 1'b0;
        out_color_d  = '0;
        if (s1_valid_q) begin
            if (s1_idx_q == '0) begin
                out_transp_d = 1'b1;
            end else if (flash_cnt_q != '0) begin
                out_color_d = '1;
            end else begin
                out_color_d = rd_color_c;
            end
        end
    end

    // S2 output registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_valid_q  <= 1'b0;
            out_color_q  <= '0;
            out_transp_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_color_q  <= out_color_d;
            out_transp_q <= out_transp_d;
        end
    end

    // Flash counter next state: a (re)start load wins over a frame tick.
    always_comb begin
        flash_cnt_d = flash_cnt_q;
        if (flash_start) begin
            flash_cnt_d = CNT_W'(FLASH_FRAMES);
        end else if (frame_tick && (flash_cnt_q != '0)) begin
            flash_cnt_d = flash_cnt_q - CNT_W'(1);
        end
        flash_act_d = (flash_cnt_d != '0);
    end

    // Flash counter and its registered activity flag
    always_ff @(posedge Clk) begin
        if (Reset) begin
            flash_cnt_q <= '0;
            flash_act_q <= 1'b0;
        end else begin
            flash_cnt_q <= flash_cnt_d;
            flash_act_q <= flash_act_d;
        end
    end

    assign pix_valid_out   = out_valid_q;
    assign color_out       = out_color_q;
    assign transparent_out = out_transp_q;
    assign flash_active    = flash_act_q;

endmodule

// File: tb/tb_sprite_palette_lut.sv
// Testbench for sprite_palette_lut: a cycle-level reference model plus directed and random stimulus.
module tb_sprite_palette_lut;

    localparam int unsigned NP = 5;
    localparam int unsigned IW = 3;
    localparam int unsigned CW = 12;
    localparam int unsigned FF = 8;
    localparam int unsigned PW = 3;
    localparam int NC = 8;

    logic          Clk;
    logic          Reset;
    logic          pix_valid_in;
    logic [PW-1:0] palette_sel;
    logic [IW-1:0] color_index;
    logic          wr_en;
    logic [PW-1:0] wr_palette;
    logic [IW-1:0] wr_index;
    logic [CW-1:0] wr_color;
    logic          flash_start;
    logic          frame_tick;
    logic          pix_valid_out;
    logic [CW-1:0] color_out;
    logic          transparent_out;
    logic          flash_active;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    sprite_palette_lut #(
        .NUM_PALETTES(NP), .INDEX_W(IW), .COLOR_W(CW), .FLASH_FRAMES(FF), .PSEL_W(PW)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .pix_valid_in(pix_valid_in), .palette_sel(palette_sel), .color_index(color_index),
        .wr_en(wr_en), .wr_palette(wr_palette), .wr_index(wr_index), .wr_color(wr_color),
        .flash_start(flash_start), .frame_tick(frame_tick),
        .pix_valid_out(pix_valid_out), .color_out(color_out),
        .transparent_out(transparent_out), .flash_active(flash_active)
    );

    // Reference model state: palette contents, flash frames left, the pixel in flight.
    logic [CW-1:0] mdl_pal [NP][NC];
    logic [11:0]   boot_tbl [NC];
    int            mdl_cnt;
    bit            pend_v;
    int            pend_p;
    int            pend_i;
    logic          exp_v, exp_t, exp_f;
    logic [CW-1:0] exp_c;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < int'(NP); p++)
            for (int i = 0; i < NC; i++)
                mdl_pal[p][i] = (p == 0) ? boot_tbl[i] : '0;
        mdl_cnt = 0;
        pend_v  = 0;
        pend_p  = 0;
        pend_i  = 0;
    endtask

    task automatic idle();
        Reset = 0; pix_valid_in = 0; palette_sel = '0; color_index = '0;
        wr_en = 0; wr_palette = '0; wr_index = '0; wr_color = '0;
        flash_start = 0; frame_tick = 0;
    endtask

    task automatic pix(input int p, input int i);
        pix_valid_in = 1; palette_sel = PW'(p); color_index = IW'(i);
    endtask

    task automatic wr(input int p, input int i, input logic [CW-1:0] c);
        wr_en = 1; wr_palette = PW'(p); wr_index = IW'(i); wr_color = c;
    endtask

    // One clock: predict the outputs after the coming edge, advance, then compare.
    task automatic step();
        int rp, wp;
        if (Reset) begin
            model_reset();
            exp_v = 0; exp_t = 0; exp_c = '0; exp_f = 0;
        end else begin
            rp    = (pend_p < int'(NP)) ? pend_p : 0;
            exp_v = pend_v;
            exp_t = pend_v && (pend_i == 0);
            if (!pend_v || pend_i == 0) exp_c = '0;
            else if (mdl_cnt > 0)       exp_c = 12'hFFF;
            else                        exp_c = mdl_pal[rp][pend_i];
            wp = int'(wr_palette);
            if (wr_en && wp < int'(NP)) mdl_pal[wp][int'(wr_index)] = wr_color;
            if (flash_start)                    mdl_cnt = FF;
            else if (frame_tick && mdl_cnt > 0) mdl_cnt = mdl_cnt - 1;
            exp_f  = (mdl_cnt != 0);
            pend_v = pix_valid_in;
            pend_p = int'(palette_sel);
            pend_i = int'(color_index);
        end
        @(posedge Clk);
        #1;
        chk("pix_valid_out",   32'(pix_valid_out),   32'(exp_v));
        chk("color_out",       32'(color_out),       32'(exp_c));
        chk("transparent_out", 32'(transparent_out), 32'(exp_t));
        chk("flash_active",    32'(flash_active),    32'(exp_f));
        @(negedge Clk);
    endtask

    initial begin
        boot_tbl = '{12'h000, 12'hB00, 12'hCB1, 12'hFD0, 12'h040, 12'h3FD, 12'h456, 12'h9CD};
        idle();
        Reset = 1;
        @(negedge Clk);
        step();
        step();
        chk("reset_valid", 32'(pix_valid_out), 32'h0);
        chk("reset_flash", 32'(flash_active), 32'h0);

        // Stream palette 0 idx1..7 back-to-back.
        for (int k = 1; k <= 8; k++) begin
            idle();
            if (k <= 7) pix(0, k);
            step();
            if (k >= 2) begin
                chk("stream_color", 32'(color_out), 32'(boot_tbl[k-1]));
                chk("stream_valid", 32'(pix_valid_out), 32'h1);
            end
        end

        // Write then read, then same-cycle read/write collision.
        idle(); wr(2, 5, 12'h0F0); step();
        idle(); pix(2, 5); step();
        idle(); step();
        chk("write_read", 32'(color_out), 32'h0F0);
        idle(); pix(2, 3); step();
        idle(); wr(2, 3, 12'hABC); step();
        chk("collision_old", 32'(color_out), 32'h000);
        chk("collision_valid", 32'(pix_valid_out), 32'h1);
        idle(); pix(2, 3); step();
        idle(); step();
        chk("collision_new", 32'(color_out), 32'hABC);

        // Transparency under flash, and invalid pixels.
        idle(); flash_start = 1; pix(3, 0); step();
        idle(); step();
        chk("transp_flag", 32'(transparent_out), 32'h1);
        chk("transp_color", 32'(color_out), 32'h000);
        chk("flash_on", 32'(flash_active), 32'h1);
        idle(); step();
        chk("invalid_valid", 32'(pix_valid_out), 32'h0);

        // Full flash countdown over 8 frame ticks.
        idle(); flash_start = 1; step();
        for (int t = 1; t <= 8; t++) begin
            idle(); frame_tick = 1; pix(0, 2); step();
            if (t >= 2) chk("flash_fff", 32'(color_out), 32'hFFF);
        end
        chk("flash_done", 32'(flash_active), 32'h0);
        idle(); step();
        chk("flash_after", 32'(color_out), 32'hCB1);

        // Restart coincident with a tick at count 3 reloads to 8.
        idle(); flash_start = 1; step();
        for (int t = 0; t < 5; t++) begin idle(); frame_tick = 1; step(); end
        idle(); flash_start = 1; frame_tick = 1; step();
        for (int t = 0; t < 7; t++) begin idle(); frame_tick = 1; step(); end
        chk("restart_still_on", 32'(flash_active), 32'h1);
        idle(); frame_tick = 1; step();
        chk("restart_off", 32'(flash_active), 32'h0);

        // Out-of-range select and out-of-range writes.
        idle(); wr(5, 3, 12'h555); step();
        idle(); wr(7, 1, 12'h777); step();
        idle(); pix(5, 3); step();
        idle(); pix(7, 1); step();
        chk("oor_sel5", 32'(color_out), 32'hFD0);
        idle(); step();
        chk("oor_sel7", 32'(color_out), 32'hB00);
        for (int p = 0; p < int'(NP); p++)
            for (int i = 0; i < NC; i++) begin idle(); pix(p, i); step(); end
        idle(); step();
        idle(); step();

        // Reset in the middle of a stream.
        idle(); wr(0, 1, 12'h123); step();
        idle(); pix(0, 1); step();
        idle(); step();
        chk("pre_reset_write", 32'(color_out), 32'h123);
        idle(); flash_start = 1; pix(0, 1); step();
        idle(); pix(0, 4); step();
        idle(); pix(0, 5); Reset = 1; step();
        chk("mid_reset_valid", 32'(pix_valid_out), 32'h0);
        chk("mid_reset_color", 32'(color_out), 32'h000);
        chk("mid_reset_flash", 32'(flash_active), 32'h0);
        idle(); pix(0, 1); step();
        idle(); step();
        chk("post_reset_default", 32'(color_out), 32'hB00);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            idle();
            Reset        = ($urandom_range(0, 299) == 0);
            pix_valid_in = ($urandom_range(0, 3) != 0);
            palette_sel  = PW'($urandom_range(0, 7));
            color_index  = IW'($urandom_range(0, 7));
            wr_en        = ($urandom_range(0, 3) == 0);
            wr_palette   = PW'($urandom_range(0, 7));
            wr_index     = IW'($urandom_range(0, 7));
            wr_color     = CW'($urandom);
            flash_start  = ($urandom_range(0, 59) == 0);
            frame_tick   = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
